// File: rtl/serial_unshifter.sv
// serial_unshifter: sequential inverse of the 8-bit combinational shifter.
// It takes a shifted byte together with the amount and opcode the forward
// shifter used. It then applies the opposite move one bit position per clock
// until the pre-shift value is recovered. Rotates undo exactly. Logical shifts
// come back with the bits the shifter pushed out replaced by zeros.
module serial_unshifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    // Forward opcodes; the step below applies the opposite direction.
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_data_out;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] w_work_step;
    logic             w_last_shift;

    // One-position inverse of the forward operation selected by op.
    function automatic logic [WIDTH-1:0] undo_step(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_LSL:  r = {1'b0, v[WIDTH-1:1]};
            OP_LSR:  r = {v[WIDTH-2:0], 1'b0};
            OP_ROL:  r = {v[0], v[WIDTH-1:1]};
            OP_ROR:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign w_work_step  = undo_step(r_work, r_op);
    assign w_last_shift = (r_cnt == AMT_W'(1));

    // State register. The rest of the control is decoded from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. start is only sampled in IDLE. A zero amount skips SHIFT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Work register, counter and result register.
    // data_out is written only on the edge that enters DONE, so the previous
    // result stays visible through the whole SHIFT phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_op       <= 2'b00;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= data_in;
                        r_cnt  <= amount;
                        r_op   <= opcode;
                        if (amount == '0) begin
                            r_data_out <= data_in;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_step;
                    r_cnt  <= r_cnt - AMT_W'(1);
                    if (w_last_shift) begin
                        r_data_out <= w_work_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign data_out = r_data_out;

endmodule

// File: tb/tb_serial_unshifter.sv
// Bench for serial_unshifter. It keeps an edge-timestamp reference model.
// Expected results come from whole-word arithmetic, not bit-by-bit stepping.
// A compare process checks busy, done and data_out on every falling edge.
module tb_serial_unshifter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic [1:0] opcode;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    int checks   = 0;
    int failures = 0;

    serial_unshifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .amount   (amount),
        .opcode   (opcode),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inverse of the forward op, computed on the whole word at once.
    function automatic logic [7:0] ref_undo(input logic [7:0] d, input int a, input logic [1:0] op);
        logic [15:0] t;
        t = {d, d};
        case (op)
            2'b00:   return d >> a;
            2'b01:   return 8'((16'(d) << a) & 16'hFF);
            2'b10:   begin t = t >> a; return t[7:0]; end
            default: begin t = t << a; return t[15:8]; end
        endcase
    endfunction

    // Forward shifter, used to build round-trip stimulus.
    function automatic logic [7:0] fwd_shift(input logic [7:0] d, input int a, input logic [1:0] op);
        logic [15:0] t;
        t = {d, d};
        case (op)
            2'b00:   return 8'((16'(d) << a) & 16'hFF);
            2'b01:   return d >> a;
            2'b10:   begin t = t << a; return t[15:8]; end
            default: begin t = t >> a; return t[7:0]; end
        endcase
    endfunction

    // Reference model in edge timestamps.
    // s_edge: edge that accepted the request. d_edge: edge that entered DONE.
    int         k      = 0;
    int         s_edge = -10;
    int         d_edge = -10;
    logic [7:0] m_res  = 8'h00;
    logic [7:0] m_dout = 8'h00;
    bit         m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            k++;
            if (reset) begin
                s_edge  = -10;
                d_edge  = -10;
                m_dout  = 8'h00;
                m_valid = 1'b1;
            end else begin
                if (start && k >= d_edge + 2) begin
                    s_edge = k;
                    d_edge = k + int'(amount);
                    m_res  = ref_undo(data_in, int'(amount), opcode);
                end
                if (k == d_edge) m_dout = m_res;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("busy", 32'(busy), 32'(k >= s_edge && k <= d_edge));
                check("done", 32'(done), 32'(k == d_edge));
                check("data_out", 32'(data_out), 32'(m_dout));
            end
        end
    end

    // One request. Returns the result at done and the edge count from the start edge.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic [1:0] op,
                          output logic [7:0] res, output int lat);
        @(negedge clk);
        data_in = d;
        amount  = a;
        opcode  = op;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
        amount  = 3'($urandom);
        opcode  = 2'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'(done), 32'(1));
        res = data_out;
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] exp8;
        int         lat;
        int         busy_cnt;

        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        amount  = 3'd0;
        opcode  = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_dout", 32'(data_out), 32'(0));
        reset = 1'b0;

        // Pin the model to hand-computed values.
        check("model_lsl", 32'(ref_undo(8'h02, 1, 2'b00)), 32'h01);
        check("model_rol", 32'(ref_undo(8'h1D, 1, 2'b10)), 32'h8E);
        check("model_ror", 32'(ref_undo(8'hD1, 3, 2'b11)), 32'h8E);
        check("model_zero", 32'(ref_undo(8'hA5, 0, 2'b01)), 32'hA5);
        check("model_full", 32'(ref_undo(8'h01, 7, 2'b01)), 32'h80);

        run_op(8'h02, 3'd1, 2'b00, res, lat);
        check("lsl_undo_val", 32'(res), 32'h01);
        check("lsl_undo_lat", 32'(lat), 32'(2));
        run_op(8'h1D, 3'd1, 2'b10, res, lat);
        check("rol_undo_val", 32'(res), 32'h8E);
        run_op(8'hD1, 3'd3, 2'b11, res, lat);
        check("ror_undo_val", 32'(res), 32'h8E);
        check("ror_undo_lat", 32'(lat), 32'(4));
        run_op(8'hA5, 3'd0, 2'b01, res, lat);
        check("zero_amt_val", 32'(res), 32'hA5);
        check("zero_amt_lat", 32'(lat), 32'(1));
        run_op(8'h01, 3'd7, 2'b01, res, lat);
        check("full_amt_val", 32'(res), 32'h80);
        check("full_amt_lat", 32'(lat), 32'(8));

        // Busy count for the amount=3 case.
        @(negedge clk);
        data_in = 8'hD1; amount = 3'd3; opcode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(4));

        // start during SHIFT is ignored.
        @(negedge clk);
        data_in = 8'h40; amount = 3'd4; opcode = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        data_in = 8'hFF; amount = 3'd1; opcode = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_start_done", 32'(done), 32'(1));
        check("ignore_start_val", 32'(data_out), 32'h00);
        @(negedge clk);
        check("ignore_start_idle", 32'(busy), 32'(0));

        // Reset mid-SHIFT aborts the request with no done pulse.
        @(negedge clk);
        data_in = 8'h3C; amount = 3'd5; opcode = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_dout", 32'(data_out), 32'(0));
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) busy_cnt++;
        end
        check("abort_no_done", 32'(busy_cnt), 32'(0));

        // Round trip through the forward shifter.
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 8; a++) begin
                run_op(fwd_shift(8'h8E, a, 2'(op)), 3'(a), 2'(op), res, lat);
                if (op >= 2)       exp8 = 8'h8E;
                else if (op == 0)  exp8 = 8'h8E & 8'(8'hFF >> a);
                else               exp8 = 8'h8E & 8'((16'hFF << a) & 16'hFF);
                check($sformatf("roundtrip_op%0d_a%0d", op, a), 32'(res), 32'(exp8));
            end
        end

        // Randomized traffic with occasional resets; the compare process checks it.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom);
            amount  = 3'($urandom);
            opcode  = 2'($urandom);
            reset   = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
